// File: rtl/shift_out_8b_pkg.sv
// Shared definitions for the shift_out_8b parallel-in/serial-out stage:
// FSM state encodings, default word width and the shift-length helper.
package shift_out_8b_pkg;

  localparam int SO_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    SO_IDLE  = 2'd0,
    SO_SHIFT = 2'd1,
    SO_DONE  = 2'd2
  } so_state_t;

  // Number of serial bits per word: the data bits plus an optional parity bit.
  function automatic int so_nbits(input int width, input bit parity_en);
    return parity_en ? (width + 1) : width;
  endfunction

endpackage

// File: rtl/shift_out_8b_bit_counter.sv
// Synchronous up-counter with clear and enable, flagging the terminal count
// when the running value equals i_last.
module shift_out_8b_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == i_last);

endmodule

// File: rtl/shift_out_8b.sv
// Parallel-in/serial-out shifter: captures D on load_valid && load_ready and
// serialises it with sout_valid, then pulses done. Define SHIFT_OUT_PARITY_EN
// to append an even-parity bit after the data bits.
module shift_out_8b
  import shift_out_8b_pkg::*;
#(
  parameter int WIDTH     = SO_DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

`ifdef SHIFT_OUT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int NBITS = so_nbits(WIDTH, PAR_EN);
  localparam int CNT_W = $clog2(NBITS + 1);

  so_state_t        r_state;
  logic [NBITS-1:0] r_shreg;
  logic             r_busy;
  logic             r_done;
  logic             w_load;
  logic             w_tc;
  logic             w_out_bit;

  // The parity bit lives at the far end of the shift register, so it leaves
  // the output tap right after the last data bit with no extra muxing.
  function automatic logic [NBITS-1:0] load_word(input logic [WIDTH-1:0] d);
`ifdef SHIFT_OUT_PARITY_EN
    if (LSB_FIRST) begin
      return {^d, d};
    end
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  function automatic logic [NBITS-1:0] shift_word(input logic [NBITS-1:0] s);
    if (LSB_FIRST) begin
      return {1'b0, s[NBITS-1:1]};
    end
    return {s[NBITS-2:0], 1'b0};
  endfunction

  assign w_load = (r_state == SO_IDLE) && load_valid;

  shift_out_8b_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_load),
    .i_en   (r_state == SO_SHIFT),
    .i_last (CNT_W'(NBITS - 1)),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SO_IDLE;
      r_shreg <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        SO_IDLE: begin
          if (load_valid) begin
            r_shreg <= load_word(D);
            r_busy  <= 1'b1;
            r_state <= SO_SHIFT;
          end
        end
        SO_SHIFT: begin
          r_shreg <= shift_word(r_shreg);
          if (w_tc) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= SO_DONE;
          end
        end
        SO_DONE: begin
          r_done  <= 1'b0;
          r_state <= SO_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= SO_IDLE;
        end
      endcase
    end
  end

  assign w_out_bit  = LSB_FIRST ? r_shreg[0] : r_shreg[NBITS-1];
  assign sout_valid = (r_state == SO_SHIFT);
  assign sout       = sout_valid & w_out_bit;
  assign load_ready = (r_state == SO_IDLE);
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_shift_out_8b.sv
// Directed bench for shift_out_8b: an LSB-first and an MSB-first instance
// share stimulus; expected serial sequences come from a hand-filled table.
module tb_shift_out_8b;

`ifdef SHIFT_OUT_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct {
    logic [7:0] d;
    logic [7:0] seq_l;  // bit i = i-th serial bit, LSB-first instance
    logic [7:0] seq_m;  // bit i = i-th serial bit, MSB-first instance
    logic       par;    // even parity bit sent last when enabled
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       lv;
  logic [7:0] D;

  logic ready_l, sout_l, sv_l, busy_l, done_l;
  logic ready_m, sout_m, sv_m, busy_m, done_m;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  vec_t tbl [7];

  shift_out_8b #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .D          (D),
    .load_valid (lv),
    .load_ready (ready_l),
    .sout       (sout_l),
    .sout_valid (sv_l),
    .busy       (busy_l),
    .done       (done_l)
  );

  shift_out_8b #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .D          (D),
    .load_valid (lv),
    .load_ready (ready_m),
    .sout       (sout_m),
    .sout_valid (sv_m),
    .busy       (busy_m),
    .done       (done_m)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_l) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " ready_l"}, ready_l, 1'b1);
    chk({nm, " ready_m"}, ready_m, 1'b1);
    chk({nm, " sout_l"},  sout_l,  1'b0);
    chk({nm, " sout_m"},  sout_m,  1'b0);
    chk({nm, " sv_l"},    sv_l,    1'b0);
    chk({nm, " sv_m"},    sv_m,    1'b0);
    chk({nm, " busy"},    busy_l,  1'b0);
    chk({nm, " done"},    done_l,  1'b0);
  endtask

  // Checks the NB serial bits of the word currently being shifted.
  task automatic chk_bits(input string nm, input vec_t v);
    logic el, em;
    for (int i = 0; i < NB; i++) begin
      el = (i < 8) ? v.seq_l[i[2:0]] : v.par;
      em = (i < 8) ? v.seq_m[i[2:0]] : v.par;
      chk($sformatf("%s lsb bit%0d", nm, i), sout_l, el);
      chk($sformatf("%s msb bit%0d", nm, i), sout_m, em);
      chk($sformatf("%s sv bit%0d", nm, i), sv_l & sv_m, 1'b1);
      if (i == 0) begin
        chk({nm, " busy"},  busy_l,  1'b1);
        chk({nm, " ready"}, ready_l, 1'b0);
      end
      step();
    end
  endtask

  task automatic chk_done(input string nm);
    chk({nm, " done_l"},  done_l,  1'b1);
    chk({nm, " done_m"},  done_m,  1'b1);
    chk({nm, " busy"},    busy_l,  1'b0);
    chk({nm, " sv"},      sv_l | sv_m, 1'b0);
    chk({nm, " sout"},    sout_l | sout_m, 1'b0);
    chk({nm, " ready"},   ready_l, 1'b0);
  endtask

  task automatic run_word(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    D  = v.d;
    lv = 1'b1;
    step();
    lv = 1'b0;
    D  = 8'h00;
    chk_bits(nm, v);
    chk_done(nm);
    step();
    chk({nm, " ready after"}, ready_l & ready_m, 1'b1);
    chk({nm, " done cleared"}, done_l, 1'b0);
  endtask

  initial begin
    int c0;
    vec_t w0f, wf0;

    tbl[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    tbl[1] = '{8'h81, 8'h81, 8'h81, 1'b0};
    tbl[2] = '{8'h07, 8'h07, 8'hE0, 1'b1};
    tbl[3] = '{8'h03, 8'h03, 8'hC0, 1'b0};
    tbl[4] = '{8'h96, 8'h96, 8'h69, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
    w0f    = '{8'h0F, 8'h0F, 8'hF0, 1'b0};
    wf0    = '{8'hF0, 8'hF0, 8'h0F, 1'b0};

    reset = 1'b1;
    lv    = 1'b0;
    D     = 8'h00;
    step();
    step();
    chk_idle("reset");
    reset = 1'b0;
    step();
    chk_idle("idle");

    for (int k = 0; k < 7; k++) begin
      run_word(tbl[k], k);
    end

    // load_valid held high while D changes mid-shift
    c0 = done_cnt;
    D  = w0f.d;
    lv = 1'b1;
    step();
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("held0 lsb bit%0d", i), sout_l, (i < 8) ? w0f.seq_l[i[2:0]] : w0f.par);
      chk($sformatf("held0 msb bit%0d", i), sout_m, (i < 8) ? w0f.seq_m[i[2:0]] : w0f.par);
      if (i == 2) D = wf0.d;
      step();
    end
    chk_done("held0");
    step();
    chk("held idle ready", ready_l, 1'b1);
    chk("held idle busy", busy_l, 1'b0);
    step();
    lv = 1'b0;
    chk_bits("held1", wf0);
    chk_done("held1");
    step();
    chki("held done pulses", done_cnt - c0, 2);

    // reset during the 4th shift cycle aborts the word
    D  = 8'hFF;
    lv = 1'b1;
    step();
    lv = 1'b0;
    step();
    step();
    step();
    chk("abort pre busy", busy_l, 1'b1);
    c0    = done_cnt;
    reset = 1'b1;
    step();
    chk_idle("abort");
    reset = 1'b0;
    for (int i = 0; i < NB + 2; i++) step();
    chki("abort no done", done_cnt - c0, 0);
    run_word(tbl[0], 10);

    // reset wins over a simultaneous load request
    reset = 1'b1;
    lv    = 1'b1;
    D     = 8'hA5;
    step();
    chk_idle("rst+load");
    reset = 1'b0;
    lv    = 1'b0;
    step();
    chk("rst+load after busy", busy_l, 1'b0);
    chk("rst+load after ready", ready_l, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
